// File: rtl/adder_ctrl_pkg.sv
// Shared types for the round-robin adder arbiter.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ADD,
    DONE
  } arb_state_t;

  typedef logic req_idx_t;

  localparam int unsigned NUM_REQ = 2;

  function automatic logic [NUM_REQ-1:0] idx_onehot(req_idx_t idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/operand/result bundle between two clients and the adder arbiter.
interface adder_arbiter_if
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 16
);

  logic [NUM_REQ-1:0]   req;
  logic [BIT_WIDTH-1:0] a0;
  logic [BIT_WIDTH-1:0] b0;
  logic                 cin0;
  logic [BIT_WIDTH-1:0] a1;
  logic [BIT_WIDTH-1:0] b1;
  logic                 cin1;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [BIT_WIDTH-1:0] sum;
  logic                 overflow;
  logic                 busy;

  modport master (
    output req, a0, b0, cin0, a1, b1, cin1,
    input  gnt, done, sum, overflow, busy
  );

  modport slave (
    input  req, a0, b0, cin0, a1, b1, cin1,
    output gnt, done, sum, overflow, busy
  );

endinterface

// File: rtl/adder_nbit.sv
// Unsigned ripple-style adder with carry-in and carry-out.
module adder_nbit #(
  parameter int unsigned BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder_nbit between two requesters; operands and
// results are registered, one add issued every four cycles at most.
module adder_arbiter
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  adder_arbiter_if.slave bus
);

  arb_state_t           state_q, state_d;
  req_idx_t             winner_q, winner_d;
  req_idx_t             last_q;
  logic [BIT_WIDTH-1:0] op_a_q, op_b_q;
  logic                 op_cin_q;
  logic [BIT_WIDTH-1:0] sum_q;
  logic                 ovf_q;

  logic [BIT_WIDTH-1:0] sel_a, sel_b, add_sum;
  logic                 sel_cin, add_co;

  assign sel_a   = winner_q ? bus.a1   : bus.a0;
  assign sel_b   = winner_q ? bus.b1   : bus.b0;
  assign sel_cin = winner_q ? bus.cin1 : bus.cin0;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          state_d = LOAD;
          // Tie goes to whoever did not win last time.
          winner_d = (&bus.req) ? ~last_q : bus.req[1];
        end
      end
      LOAD:    state_d = ADD;
      ADD:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_cin_q <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      if (state_q == LOAD) begin
        op_a_q   <= sel_a;
        op_b_q   <= sel_b;
        op_cin_q <= sel_cin;
      end
      if (state_q == ADD) begin
        sum_q  <= add_sum;
        ovf_q  <= add_co;
        last_q <= winner_q;
      end
    end
  end

  adder_nbit #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_adder (
    .a        (op_a_q),
    .b        (op_b_q),
    .cin      (op_cin_q),
    .sum      (add_sum),
    .carry_out(add_co)
  );

  assign bus.gnt      = (state_q == IDLE) ? '0 : idx_onehot(winner_q);
  assign bus.done     = (state_q == DONE) ? idx_onehot(winner_q) : '0;
  assign bus.sum      = sum_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst && state_q == LOAD) begin
      assert (!$isunknown({sel_a, sel_b, sel_cin}))
      else $error("adder_arbiter: unknown operand from requester %0d", winner_q);
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, single ops, contention, stability, abort.
module tb_adder_arbiter;
  import adder_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  adder_arbiter_if #(.BIT_WIDTH(16)) bus ();

  adder_arbiter #(
    .BIT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.gnt, bus.done, bus.busy, bus.overflow} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: gnt=%b done=%b busy=%b ovf=%b, required all 0",
               bus.gnt, bus.done, bus.busy, bus.overflow);
    end
    n_cmp++;
    if (bus.sum !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_sum: got %h, required 0000", bus.sum);
    end
  endtask

  task automatic test_single();
    bus.req = 2'b01; bus.a0 = 16'h0003; bus.b0 = 16'h0004; bus.cin0 = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      n_cmp++;
      if (bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL single_gnt[%0d]: gnt=%b busy=%b, required 01/1", n, bus.gnt, bus.busy);
      end
      n_cmp++;
      if (bus.done !== ((n == 3) ? 2'b01 : 2'b00)) begin
        n_bad++;
        $display("FAIL single_done[%0d]: got %b", n, bus.done);
      end
    end
    n_cmp++;
    if (bus.sum !== 16'h0007 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL single_sum: got %h/%b, required 0007/0", bus.sum, bus.overflow);
    end
    bus.req = 2'b00;
    tick();
    n_cmp++;
    if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.busy !== 1'b0 || bus.sum !== 16'h0007) begin
      n_bad++;
      $display("FAIL single_idle: gnt=%b done=%b busy=%b sum=%h", bus.gnt, bus.done, bus.busy,
               bus.sum);
    end
  endtask

  task automatic test_overflow();
    bus.req = 2'b10; bus.a1 = 16'hFFFF; bus.b1 = 16'h0001; bus.cin1 = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (bus.done !== 2'b10 || bus.gnt !== 2'b10) begin
      n_bad++;
      $display("FAIL ovf_done: done=%b gnt=%b, required 10/10", bus.done, bus.gnt);
    end
    n_cmp++;
    if (bus.sum !== 16'h0001 || bus.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sum: got %h/%b, required 0001/1", bus.sum, bus.overflow);
    end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [15:0] exp_s;
    logic        exp_o;
    bus.req = 2'b11;
    bus.a0 = 16'd100;    bus.b0 = 16'd23;     bus.cin0 = 1'b1;
    bus.a1 = 16'h8000;   bus.b1 = 16'h8000;   bus.cin1 = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      // Expected order 0,1,0,1 with a 4-cycle issue interval.
      exp_g = (n % 4 == 0) ? 2'b00 : ((((n - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10);
      n_cmp++;
      if (bus.gnt !== exp_g) begin
        n_bad++;
        $display("FAIL cont_gnt[%0d]: got %b, required %b", n, bus.gnt, exp_g);
      end
      n_cmp++;
      if (bus.done !== ((n % 4 == 3) ? exp_g : 2'b00)) begin
        n_bad++;
        $display("FAIL cont_done[%0d]: got %b", n, bus.done);
      end
      if (n % 4 == 3) begin
        exp_s = (exp_g == 2'b01) ? 16'h007C : 16'h0000;
        exp_o = (exp_g == 2'b10);
        n_cmp++;
        if (bus.sum !== exp_s || bus.overflow !== exp_o) begin
          n_bad++;
          $display("FAIL cont_sum[%0d]: got %h/%b, required %h/%b", n, bus.sum, bus.overflow,
                   exp_s, exp_o);
        end
      end
      if (n == 15) bus.req = 2'b00;
    end
  endtask

  task automatic test_stability();
    bus.req = 2'b01; bus.a0 = 16'd5; bus.b0 = 16'd1; bus.cin0 = 1'b0;
    tick(); tick();
    bus.a0 = 16'd9;
    tick();
    n_cmp++;
    if (bus.done !== 2'b01 || bus.sum !== 16'd6 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL stable_sum: done=%b sum=%h ovf=%b, required 01/0006/0", bus.done, bus.sum,
               bus.overflow);
    end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_abort();
    bus.req = 2'b01; bus.a0 = 16'd7; bus.b0 = 16'd8; bus.cin0 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.gnt, bus.done, bus.busy, bus.overflow} !== 6'b0 || bus.sum !== 16'h0000) begin
      n_bad++;
      $display("FAIL abort_async: gnt=%b done=%b busy=%b sum=%h ovf=%b", bus.gnt, bus.done,
               bus.busy, bus.sum, bus.overflow);
    end
    bus.req = 2'b00;
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      n_cmp++;
      if (bus.done !== 2'b00 || bus.sum !== 16'h0000 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_quiet[%0d]: done=%b sum=%h busy=%b", n, bus.done, bus.sum, bus.busy);
      end
    end
    bus.req = 2'b01; bus.a0 = 16'd2; bus.b0 = 16'd2;
    tick(); tick(); tick();
    n_cmp++;
    if (bus.done !== 2'b01 || bus.sum !== 16'd4 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_retry: done=%b sum=%h ovf=%b, required 01/0004/0", bus.done, bus.sum,
               bus.overflow);
    end
    bus.req = 2'b00;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.req = 2'b00;
    bus.a0 = '0; bus.b0 = '0; bus.cin0 = 1'b0;
    bus.a1 = '0; bus.b1 = '0; bus.cin1 = 1'b0;
    #1;
    test_reset();
    tick();
    rst = 1'b0;
    tick();
    test_single();
    test_overflow();
    test_contention();
    test_stability();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
